// File: rtl/btn_pkg.sv
// Shared state type and default timing for the button pulse generator.
package btn_pkg;

  localparam int DEB_W = 16;
  localparam int TMR_W = 24;

  localparam logic [DEB_W-1:0] DEB_CYCLES_DEF    = 16'd50000;
  localparam logic [TMR_W-1:0] REPEAT_DELAY_DEF  = 24'd10000000;
  localparam logic [TMR_W-1:0] REPEAT_PERIOD_DEF = 24'd2500000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // A wait of N cycles counts N-1 down to 0; N=0 behaves like N=1.
  function automatic logic [TMR_W-1:0] tc_load(input logic [TMR_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, consecutive-sample debouncer and
// registered rising-edge strobe.
module btn_debounce
  import btn_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam logic [DEB_W-1:0] DEB_TC = (DEB_CYCLES == '0) ? '0 : DEB_CYCLES - 1'b1;

  logic [1:0]       sync_q, sync_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             dly_q, dly_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[0], btn_i};
    deb_d  = deb_q;
    cnt_d  = '0;
    // A sample that agrees with the current level restarts the window.
    if (sync_q[1] != deb_q) begin
      if (cnt_q >= DEB_TC) deb_d = sync_q[1];
      else                 cnt_d = cnt_q + 1'b1;
    end
    dly_d  = deb_q;
    rise_d = deb_q & ~dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
    end
  end

  assign lvl_o  = deb_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Increment/decrement/clear strobes from raw buttons, with optional hold-to-repeat.
// Define BTN_AUTO_REPEAT_EN to build the repeat FSMs and timers.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter logic [TMR_W-1:0] REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter logic [TMR_W-1:0] REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_incr_i,
  input  logic btn_decr_i,
  input  logic btn_clr_i,
  output logic pulse_incr_o,
  output logic pulse_decr_o,
  output logic sft_rst_o
);

  logic [2:0] btn_raw, lvl, rise;
  logic [1:0] rpt;
  logic       block;
  logic       inc_ev, dec_ev;
  logic       pulse_incr_q, pulse_incr_d;
  logic       pulse_decr_q, pulse_decr_d;
  logic       sft_rst_q, sft_rst_d;

  assign btn_raw = {btn_clr_i, btn_decr_i, btn_incr_i};

  for (genvar g = 0; g < 3; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_raw[g]),
      .lvl_o  (lvl[g]),
      .rise_o (rise[g])
    );
  end

  assign block = lvl[0] & lvl[1];

`ifdef BTN_AUTO_REPEAT_EN
  // state  | meaning
  // IDLE   | released, or held in an incr/decr conflict
  // HOLD   | pressed, counting down the initial repeat delay
  // REPEAT | pressed, strobing once per repeat period
  localparam logic [TMR_W-1:0] DLY_LD = tc_load(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] PER_LD = tc_load(REPEAT_PERIOD);

  rpt_state_e       state_q [2];
  rpt_state_e       state_d [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];
  logic             block_q, block_d;

  always_comb begin
    block_d = block;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = (tmr_q[i] != '0) ? tmr_q[i] - 1'b1 : '0;
      rpt[i]     = 1'b0;
      if (block || !lvl[i]) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          // Start on the press strobe, or when a conflict clears while still held.
          IDLE: begin
            if (rise[i] || block_q) begin
              state_d[i] = HOLD;
              tmr_d[i]   = DLY_LD;
            end
          end
          HOLD: begin
            if (tmr_q[i] == '0) begin
              rpt[i]     = 1'b1;
              state_d[i] = REPEAT;
              tmr_d[i]   = PER_LD;
            end
          end
          REPEAT: begin
            if (tmr_q[i] == '0) begin
              rpt[i]   = 1'b1;
              tmr_d[i] = PER_LD;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        tmr_q[i]   <= '0;
      end
    end else begin
      block_q <= block_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
    end
  end
`else
  assign rpt = 2'b00;
`endif

  // Clear wins over incr/decr; simultaneous incr and decr cancel each other.
  always_comb begin
    inc_ev       = rise[0] | rpt[0];
    dec_ev       = rise[1] | rpt[1];
    sft_rst_d    = rise[2];
    pulse_incr_d = inc_ev & ~dec_ev & ~block & ~sft_rst_d;
    pulse_decr_d = dec_ev & ~inc_ev & ~block & ~sft_rst_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_incr_q <= 1'b0;
      pulse_decr_q <= 1'b0;
      sft_rst_q    <= 1'b0;
    end else begin
      pulse_incr_q <= pulse_incr_d;
      pulse_decr_q <= pulse_decr_d;
      sft_rst_q    <= sft_rst_d;
    end
  end

  assign pulse_incr_o = pulse_incr_q;
  assign pulse_decr_o = pulse_decr_q;
  assign sft_rst_o    = sft_rst_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen at DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expected strobe cycles depend on whether BTN_AUTO_REPEAT_EN is defined.
module tb_btn_pulse_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_incr, btn_decr, btn_clr;
  logic pulse_incr_o, pulse_decr_o, sft_rst_o;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  int tp;
  int incr_q[$];
  int decr_q[$];
  int srst_q[$];
  int want[$];

  btn_pulse_gen #(
    .DEB_CYCLES    (16'd4),
    .REPEAT_DELAY  (24'd20),
    .REPEAT_PERIOD (24'd8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_incr_i   (btn_incr),
    .btn_decr_i   (btn_decr),
    .btn_clr_i    (btn_clr),
    .pulse_incr_o (pulse_incr_o),
    .pulse_decr_o (pulse_decr_o),
    .sft_rst_o    (sft_rst_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log strobes by the posedge number they followed.
  always @(negedge clk) begin
    if (pulse_incr_o) incr_q.push_back(cyc);
    if (pulse_decr_o) decr_q.push_back(cyc);
    if (sft_rst_o)    srst_q.push_back(cyc);
    if (pulse_incr_o && pulse_decr_o) overlap++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_list(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_q();
    incr_q.delete();
    decr_q.delete();
    srst_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_incr = 1'b0;
    btn_decr = 1'b0;
    btn_clr  = 1'b0;

    run_to(1);
    chk("rst_incr", pulse_incr_o, 0);
    chk("rst_decr", pulse_decr_o, 0);
    chk("rst_srst", sft_rst_o, 0);
    run_to(3);
    rst_n = 1'b1;

    // Single press: sampled from edge 10, strobe after edge 17, none on release.
    run_to(9);  btn_incr = 1'b1;
    run_to(24); btn_incr = 1'b0;
    run_to(45);
    want = '{17};
    chk_list("press", incr_q, want);
    want.delete();
    chk_list("press_decr", decr_q, want);
    chk_list("press_srst", srst_q, want);
    clear_q();

    // Glitches: 3 samples rejected, 4 samples accepted once.
    run_to(50); btn_incr = 1'b1;
    run_to(53); btn_incr = 1'b0;
    run_to(70);
    want.delete();
    chk_list("glitch3", incr_q, want);
    btn_incr = 1'b1;
    run_to(74); btn_incr = 1'b0;
    run_to(110);
    want = '{78};
    chk_list("glitch4", incr_q, want);
    clear_q();

    // Decrement held 60 cycles.
    run_to(120); btn_decr = 1'b1;
    run_to(180); btn_decr = 1'b0;
    run_to(210);
`ifdef BTN_AUTO_REPEAT_EN
    want = '{128, 148, 156, 164, 172, 180};
`else
    want = '{128};
`endif
    chk_list("hold_decr", decr_q, want);
    want.delete();
    chk_list("hold_incr", incr_q, want);
    clear_q();

    // Incr and decr together, then decr released while incr stays held.
    run_to(220); btn_incr = 1'b1; btn_decr = 1'b1;
    run_to(260); btn_decr = 1'b0;
    run_to(290); btn_incr = 1'b0;
    run_to(320);
`ifdef BTN_AUTO_REPEAT_EN
    want = '{287, 295};
`else
    want.delete();
`endif
    chk_list("both_incr", incr_q, want);
    want.delete();
    chk_list("both_decr", decr_q, want);
    clear_q();

    // Clear strobe lands on an incr strobe: clear wins, clear never repeats.
    run_to(330); btn_incr = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
    run_to(358); btn_clr = 1'b1;
    run_to(378); btn_clr = 1'b0;
    run_to(385); btn_incr = 1'b0;
    run_to(410);
    want = '{338, 358, 374, 382, 390};
    chk_list("clr_incr", incr_q, want);
    want = '{366};
    chk_list("clr_srst", srst_q, want);
`else
    btn_clr = 1'b1;
    run_to(350); btn_clr = 1'b0;
    run_to(385); btn_incr = 1'b0;
    run_to(410);
    want.delete();
    chk_list("clr_incr", incr_q, want);
    want = '{338};
    chk_list("clr_srst", srst_q, want);
`endif
    clear_q();

    // Reset while a strobe is high; button still held through release.
    run_to(420); btn_incr = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
    tp = 456;
`else
    tp = 428;
`endif
    run_to(tp);
    chk("rst_pre_incr", pulse_incr_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_incr", pulse_incr_o, 0);
    chk("rst_async_decr", pulse_decr_o, 0);
    chk("rst_async_srst", sft_rst_o, 0);
    clear_q();
    run_to(tp + 3);  rst_n = 1'b1;
    run_to(tp + 14); btn_incr = 1'b0;
    run_to(tp + 40);
    want = '{tp + 11};
    chk_list("rst_rel", incr_q, want);
    want.delete();
    chk_list("rst_rel_srst", srst_q, want);

    chk("incr_decr_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16'd50000, giving the number of consecutive stable samples required to accept a new button level.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 24'd10000000, giving the cycles from the press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 24'd2500000, giving the cycles between consecutive auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port btn_incr_i, input, 1 bit, a raw asynchronous increment button, active-high.
REQ-007 The block SHALL have port btn_decr_i, input, 1 bit, a raw asynchronous decrement button, active-high.
REQ-008 The block SHALL have port btn_clr_i, input, 1 bit, a raw asynchronous clear button, active-high.
REQ-009 The block SHALL have port pulse_incr_o, output, 1 bit, a one-cycle increment strobe to the downstream digit counter.
REQ-010 The block SHALL have port pulse_decr_o, output, 1 bit, a one-cycle decrement strobe to the downstream digit counter.
REQ-011 The block SHALL have port sft_rst_o, output, 1 bit, a one-cycle soft-reset strobe to the downstream digit counter.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each debouncer SHALL update its debounced level only after the synchronized input has differed from the current debounced level for DEB_CYCLES consecutive cycles; any mismatch-free sample in that window SHALL restart the count from 0.
REQ-014 A rising edge of a debounced level SHALL produce exactly one 1-cycle pulse on the matching output; total latency from a stable raw change SHALL be DEB_CYCLES+3 cycles.
REQ-015 A falling edge of a debounced level SHALL produce no pulse.
REQ-016 The per-button repeat FSM SHALL have states IDLE, HOLD and REPEAT.
REQ-017 The FSM SHALL move IDLE->HOLD on the press pulse and load a timer with REPEAT_DELAY.
REQ-018 The FSM SHALL, on HOLD timer expiry, pulse once, move to REPEAT and load the timer with REPEAT_PERIOD.
REQ-019 The FSM SHALL, in REPEAT, pulse once and reload the timer with REPEAT_PERIOD on each expiry.
REQ-020 The FSM SHALL return to IDLE from any state within one cycle of a debounced release, with no further pulses.
REQ-021 The clear button SHALL never auto-repeat.
REQ-022 If increment and decrement are both debounced-pressed, pulse_incr_o and pulse_decr_o SHALL both be suppressed, and both FSMs SHALL be held in IDLE.
REQ-023 A sft_rst_o pulse SHALL suppress any pulse_incr_o or pulse_decr_o in the same cycle.
REQ-024 pulse_incr_o and pulse_decr_o SHALL never be high in the same cycle.
REQ-025 Timers SHALL be sized to REPEAT_DELAY width and SHALL saturate, never wrap.

Reset
REQ-026 Assertion of rst_n SHALL asynchronously clear all synchronizer flops, debounced levels, counters and timers, force every FSM to IDLE, and drive all outputs to 0.
REQ-027 A raw button held high through reset release SHALL be debounced as a new press (pulse after DEB_CYCLES+3 cycles).
REQ-028 Reset asserted mid-HOLD or mid-REPEAT SHALL abort with no pulse emitted.

Configuration
REQ-029 Macro BTN_AUTO_REPEAT_EN SHALL control auto-repeat.
REQ-030 With BTN_AUTO_REPEAT_EN defined, the repeat FSMs and timers SHALL be present.
REQ-031 Without BTN_AUTO_REPEAT_EN, the FSMs and timers SHALL be compiled out, and each press SHALL yield exactly one pulse regardless of hold time.

Structure
REQ-032 Package btn_pkg SHALL hold the FSM state typedef (IDLE/HOLD/REPEAT) and default constants for DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-033 Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse) SHALL be instantiated three times.

Verification
Verification scenarios use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-034 Bench SHALL cover: raw incr high from cycle 10 -> single pulse_incr_o at cycle 17; none on release.
REQ-035 Bench SHALL cover: incr glitch high for 3 cycles -> no pulse; 4-cycle glitch followed by release -> exactly one pulse.
REQ-036 Bench SHALL cover: decr held 60 cycles with BTN_AUTO_REPEAT_EN defined -> pulses at press cycle P, P+20, P+28, P+36, P+44, P+52; without the macro -> pulse at P only.
REQ-037 Bench SHALL cover: incr and decr pressed together -> zero pulses; then release decr -> incr FSM starts, first repeat 20 cycles after it enters HOLD.
REQ-038 Bench SHALL cover: clr pressed during incr REPEAT -> sft_rst_o for 1 cycle, coincident incr pulse dropped, no clr repeat.
REQ-039 Bench SHALL cover: rst_n low mid-REPEAT -> all outputs 0 immediately; button still held at release -> pulse at DEB_CYCLES+3=7 cycles.
